// File: rtl/parking_pin_entry_pkg.sv
// Shared definitions for the parking gate PIN entry terminal:
// FSM encodings, keypad constants and digit classification.
package parking_pin_entry_pkg;

    typedef enum logic [2:0] {
        PE_IDLE      = 3'd0,
        PE_ENTRY     = 3'd1,
        PE_SEND      = 3'd2,
        PE_WAIT_RESP = 3'd3,
        PE_LOCKED    = 3'd4
    } pe_state_e;

    localparam logic [3:0] KEY_CLEAR  = 4'hA;
    localparam logic [3:0] KEY_ENTER  = 4'hB;
    localparam logic [2:0] PIN_DIGITS = 3'd4;

    function automatic logic is_digit(input logic [3:0] key);
        return (key <= 4'd9);
    endfunction

endpackage

// File: rtl/pe_timeout_counter.sv
// Idle-cycle counter with a registered expiry pulse. The pulse is high during
// the cycle in which the count sits at LIMIT-1; the count then wraps to 0.
module pe_timeout_counter #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned W = $clog2(LIMIT);
    localparam logic [W-1:0] LAST    = W'(LIMIT - 1);
    localparam logic [W-1:0] PRELAST = W'(LIMIT - 2);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         expired_q;
    logic         expired_d;

    // Next count and look-ahead expiry so the pulse lines up with LIMIT-1.
    always_comb begin
        cnt_d     = cnt_q;
        expired_d = 1'b0;
        if (clear_i) begin
            cnt_d     = '0;
            expired_d = 1'b0;
        end else if (enable_i) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + W'(1);
            end
            expired_d = (cnt_q == PRELAST);
        end else begin
            cnt_d     = cnt_q;
            expired_d = 1'b0;
        end
    end

    // Count and pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            expired_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            expired_q <= expired_d;
        end
    end

    assign expired_o = expired_q;

endmodule

// File: rtl/parking_pin_entry.sv
// Keypad PIN entry terminal: collects four BCD digits, hands the code to the
// gate controller with a one-cycle ack and reports the controller's verdict.
module parking_pin_entry
    import parking_pin_entry_pkg::*;
#(
    parameter int unsigned ENTRY_TIMEOUT = 1000,
    parameter int unsigned RESP_TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vehicle_present_i,
    input  logic        key_valid_i,
    input  logic [3:0]  key_code_i,
    input  logic        open_gate_i,
    input  logic        wrong_ping_i,
    input  logic        blocked_gate_i,
    output logic [15:0] code_o,
    output logic        code_ack_o,
    output logic [2:0]  digit_count_o,
    output logic        busy_o,
    output logic        result_ok_o,
    output logic        result_bad_o,
    output logic        locked_o
);

    pe_state_e   state_q;
    pe_state_e   state_d;
    logic [15:0] code_q;
    logic [15:0] code_d;
    logic [2:0]  count_q;
    logic [2:0]  count_d;
    logic        code_ack_q;
    logic        busy_q;
    logic        result_ok_q;
    logic        result_ok_d;
    logic        result_bad_q;
    logic        result_bad_d;
    logic        locked_q;

    logic        key_digit_s;
    logic        key_clear_s;
    logic        key_enter_s;
    logic        key_accept_s;
    logic        entry_clear_s;
    logic        entry_expired_s;
    logic        resp_enable_s;
    logic        resp_expired_s;

    assign key_digit_s   = key_valid_i && is_digit(key_code_i);
    assign key_clear_s   = key_valid_i && (key_code_i == KEY_CLEAR);
    assign key_enter_s   = key_valid_i && (key_code_i == KEY_ENTER);
    assign key_accept_s  = key_digit_s || key_clear_s || key_enter_s;

    // Entry timer only runs in ENTRY and restarts on any meaningful key.
    assign entry_clear_s = (state_q != PE_ENTRY) || key_accept_s;
    assign resp_enable_s = (state_q == PE_WAIT_RESP);

    pe_timeout_counter #(.LIMIT(ENTRY_TIMEOUT)) u_entry_timer (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (entry_clear_s),
        .enable_i  (state_q == PE_ENTRY),
        .expired_o (entry_expired_s)
    );

    pe_timeout_counter #(.LIMIT(RESP_TIMEOUT)) u_resp_timer (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (!resp_enable_s),
        .enable_i  (resp_enable_s),
        .expired_o (resp_expired_s)
    );

    // Next-state, code buffer and verdict pulse decisions.
    always_comb begin
        state_d      = state_q;
        code_d       = code_q;
        count_d      = count_q;
        result_ok_d  = 1'b0;
        result_bad_d = 1'b0;
        case (state_q)
            PE_IDLE: begin
                code_d  = 16'h0000;
                count_d = 3'd0;
                if (vehicle_present_i) begin
                    state_d = PE_ENTRY;
                end else begin
                    state_d = PE_IDLE;
                end
            end
            PE_ENTRY: begin
                // Departure wins over any key arriving in the same cycle.
                if (!vehicle_present_i) begin
                    state_d = PE_IDLE;
                    code_d  = 16'h0000;
                    count_d = 3'd0;
                end else if (key_digit_s) begin
                    if (count_q < PIN_DIGITS) begin
                        code_d  = {code_q[11:0], key_code_i};
                        count_d = count_q + 3'd1;
                    end else begin
                        code_d  = code_q;
                    end
                end else if (key_clear_s) begin
                    code_d  = 16'h0000;
                    count_d = 3'd0;
                end else if (key_enter_s) begin
                    if (count_q == PIN_DIGITS) begin
                        state_d = PE_SEND;
                    end else begin
                        state_d = PE_ENTRY;
                    end
                end else if (entry_expired_s) begin
                    code_d  = 16'h0000;
                    count_d = 3'd0;
                end else begin
                    state_d = PE_ENTRY;
                end
            end
            PE_SEND: begin
                state_d = PE_WAIT_RESP;
            end
            PE_WAIT_RESP: begin
                if (blocked_gate_i) begin
                    state_d = PE_LOCKED;
                end else if (open_gate_i) begin
                    state_d     = PE_IDLE;
                    result_ok_d = 1'b1;
                    code_d      = 16'h0000;
                    count_d     = 3'd0;
                end else if (wrong_ping_i || resp_expired_s) begin
                    state_d      = PE_ENTRY;
                    result_bad_d = 1'b1;
                    code_d       = 16'h0000;
                    count_d      = 3'd0;
                end else begin
                    state_d = PE_WAIT_RESP;
                end
            end
            PE_LOCKED: begin
                state_d = PE_LOCKED;
            end
            default: begin
                state_d = PE_IDLE;
                code_d  = 16'h0000;
                count_d = 3'd0;
            end
        endcase
    end

    // State and output registers; status flags decode the upcoming state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= PE_IDLE;
            code_q       <= 16'h0000;
            count_q      <= 3'd0;
            code_ack_q   <= 1'b0;
            busy_q       <= 1'b0;
            result_ok_q  <= 1'b0;
            result_bad_q <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            code_q       <= code_d;
            count_q      <= count_d;
            code_ack_q   <= (state_d == PE_SEND);
            busy_q       <= (state_d == PE_SEND) || (state_d == PE_WAIT_RESP);
            result_ok_q  <= result_ok_d;
            result_bad_q <= result_bad_d;
            locked_q     <= (state_d == PE_LOCKED);
        end
    end

    assign code_o        = code_q;
    assign digit_count_o = count_q;
    assign code_ack_o    = code_ack_q;
    assign busy_o        = busy_q;
    assign result_ok_o   = result_ok_q;
    assign result_bad_o  = result_bad_q;
    assign locked_o      = locked_q;

endmodule

// File: tb/tb_parking_pin_entry.sv
// Vector-table bench for parking_pin_entry with a scoreboard queue of
// expected output words, compared one clock after each vector is driven.
module tb_parking_pin_entry;

    localparam int unsigned ENTRY_TO = 8;
    localparam int unsigned RESP_TO  = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        vehicle_present;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        open_gate;
    logic        wrong_ping;
    logic        blocked_gate;
    logic [15:0] code;
    logic        code_ack;
    logic [2:0]  digit_count;
    logic        busy;
    logic        result_ok;
    logic        result_bad;
    logic        locked;

    parking_pin_entry #(.ENTRY_TIMEOUT(ENTRY_TO), .RESP_TIMEOUT(RESP_TO)) dut (
        .clk               (clk),
        .rst               (rst),
        .vehicle_present_i (vehicle_present),
        .key_valid_i       (key_valid),
        .key_code_i        (key_code),
        .open_gate_i       (open_gate),
        .wrong_ping_i      (wrong_ping),
        .blocked_gate_i    (blocked_gate),
        .code_o            (code),
        .code_ack_o        (code_ack),
        .digit_count_o     (digit_count),
        .busy_o            (busy),
        .result_ok_o       (result_ok),
        .result_bad_o      (result_bad),
        .locked_o          (locked)
    );

    always #5 clk = ~clk;

    // exp = {code, digit_count, code_ack, busy, result_ok, result_bad, locked}
    typedef struct {
        string       name;
        logic        rst;
        logic        vp;
        logic        kv;
        logic [3:0]  key;
        logic        og;
        logic        wp;
        logic        bg;
        logic [23:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [23:0] sb_q[$];
    int          errors = 0;
    int          checks = 0;

    function automatic void add(input string name, input logic r, input logic vp,
                                input logic kv, input logic [3:0] key, input logic og,
                                input logic wp, input logic bg, input logic [15:0] c,
                                input logic [2:0] n, input logic ack, input logic bsy,
                                input logic ok, input logic bad, input logic lk);
        vec_t v;
        v.name = name; v.rst = r; v.vp = vp; v.kv = kv; v.key = key;
        v.og = og; v.wp = wp; v.bg = bg;
        v.exp = {c, n, ack, bsy, ok, bad, lk};
        vecs.push_back(v);
    endfunction

    // Plain ENTRY-state vector: vehicle present, no verdicts, idle flags.
    function automatic void ent(input string name, input logic kv, input logic [3:0] key,
                                input logic [15:0] c, input logic [2:0] n);
        add(name, 1'b0, 1'b1, kv, key, 1'b0, 1'b0, 1'b0, c, n, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    task automatic apply(input vec_t v);
        logic [23:0] e;
        logic [23:0] act;
        rst = v.rst; vehicle_present = v.vp; key_valid = v.kv; key_code = v.key;
        open_gate = v.og; wrong_ping = v.wp; blocked_gate = v.bg;
        sb_q.push_back(v.exp);
        @(posedge clk);
        #1;
        e   = sb_q.pop_front();
        act = {code, digit_count, code_ack, busy, result_ok, result_bad, locked};
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL %s: got code=%h cnt=%0d ack/busy/ok/bad/lk=%b, expected code=%h cnt=%0d ack/busy/ok/bad/lk=%b",
                     v.name, act[23:8], act[7:5], act[4:0], e[23:8], e[7:5], e[4:0]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; vehicle_present = 1'b0; key_valid = 1'b0; key_code = 4'h0;
        open_gate = 1'b0; wrong_ping = 1'b0; blocked_gate = 1'b0;

        // Accepted PIN
        add("reset", 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        ent("idle_to_entry", 1'b0, 4'h0, 16'h0000, 3'd0);
        ent("pin_d2", 1'b1, 4'h2, 16'h0002, 3'd1);
        ent("pin_d4", 1'b1, 4'h4, 16'h0024, 3'd2);
        ent("pin_d6", 1'b1, 4'h6, 16'h0246, 3'd3);
        ent("pin_d8", 1'b1, 4'h8, 16'h2468, 3'd4);
        add("enter_2468", 1'b0, 1'b1, 1'b1, 4'hB, 1'b0, 1'b0, 1'b0, 16'h2468, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        add("send_2468", 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 16'h2468, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        add("open_gate", 1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        ent("ok_pulse_end", 1'b0, 4'h0, 16'h0000, 3'd0);

        // Editing
        ent("ed_d1", 1'b1, 4'h1, 16'h0001, 3'd1);
        ent("ed_d2", 1'b1, 4'h2, 16'h0012, 3'd2);
        ent("ed_d3", 1'b1, 4'h3, 16'h0123, 3'd3);
        ent("ed_d4", 1'b1, 4'h4, 16'h1234, 3'd4);
        ent("ed_d5_ignored", 1'b1, 4'h5, 16'h1234, 3'd4);
        ent("ed_clear", 1'b1, 4'hA, 16'h0000, 3'd0);
        ent("ed_d9a", 1'b1, 4'h9, 16'h0009, 3'd1);
        ent("ed_d9b", 1'b1, 4'h9, 16'h0099, 3'd2);
        ent("ed_enter_short", 1'b1, 4'hB, 16'h0099, 3'd2);
        ent("ed_key_c", 1'b1, 4'hC, 16'h0099, 3'd2);
        ent("ed_hold", 1'b0, 4'h0, 16'h0099, 3'd2);
        ent("ed_clear2", 1'b1, 4'hA, 16'h0000, 3'd0);

        // Rejection by verdict
        ent("rj_d1a", 1'b1, 4'h1, 16'h0001, 3'd1);
        ent("rj_d1b", 1'b1, 4'h1, 16'h0011, 3'd2);
        ent("rj_d1c", 1'b1, 4'h1, 16'h0111, 3'd3);
        ent("rj_d1d", 1'b1, 4'h1, 16'h1111, 3'd4);
        add("rj_enter", 1'b0, 1'b1, 1'b1, 4'hB, 1'b0, 1'b0, 1'b0, 16'h1111, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        add("rj_send", 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 16'h1111, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        add("rj_wrong_ping", 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        ent("rj_bad_end", 1'b0, 4'h0, 16'h0000, 3'd0);

        // Rejection by response timeout: SEND cycle plus RESP_TO-1 waiting cycles
        ent("to_d1a", 1'b1, 4'h1, 16'h0001, 3'd1);
        ent("to_d1b", 1'b1, 4'h1, 16'h0011, 3'd2);
        ent("to_d1c", 1'b1, 4'h1, 16'h0111, 3'd3);
        ent("to_d1d", 1'b1, 4'h1, 16'h1111, 3'd4);
        add("to_enter", 1'b0, 1'b1, 1'b1, 4'hB, 1'b0, 1'b0, 1'b0, 16'h1111, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < int'(RESP_TO); i++) begin
            add("to_waiting", 1'b0, 1'b1, (i % 2) == 1, 4'h5, 1'b0, 1'b0, 1'b0,
                16'h1111, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        add("to_resp_timeout", 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        ent("to_bad_end", 1'b0, 4'h0, 16'h0000, 3'd0);

        // Lockout
        ent("lk_d1", 1'b1, 4'h1, 16'h0001, 3'd1);
        ent("lk_d2", 1'b1, 4'h2, 16'h0012, 3'd2);
        ent("lk_d3", 1'b1, 4'h3, 16'h0123, 3'd3);
        ent("lk_d4", 1'b1, 4'h4, 16'h1234, 3'd4);
        add("lk_enter", 1'b0, 1'b1, 1'b1, 4'hB, 1'b0, 1'b0, 1'b0, 16'h1234, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        add("lk_send", 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 16'h1234, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        add("lk_block_open", 1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 16'h1234, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        add("lk_keys_ignored", 1'b0, 1'b0, 1'b1, 4'hA, 1'b1, 1'b1, 1'b0, 16'h1234, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        add("lk_rst", 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add("lk_post_rst", 1'b0, 1'b0, 1'b1, 4'h7, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Entry timeout: 8 idle cycles after the last key discard the entry
        ent("et_vp_on", 1'b0, 4'h0, 16'h0000, 3'd0);
        ent("et_d3a", 1'b1, 4'h3, 16'h0003, 3'd1);
        ent("et_d3b", 1'b1, 4'h3, 16'h0033, 3'd2);
        for (int i = 0; i < int'(ENTRY_TO) - 1; i++) begin
            ent("et_idle", (i == 2), 4'hE, 16'h0033, 3'd2);
        end
        ent("et_timeout", 1'b0, 4'h0, 16'h0000, 3'd0);

        // Departure beats a same-cycle digit
        ent("dp_d7", 1'b1, 4'h7, 16'h0007, 3'd1);
        add("dp_depart_key", 1'b0, 1'b0, 1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add("dp_idle_key", 1'b0, 1'b0, 1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        foreach (vecs[i]) apply(vecs[i]);
        vecs.delete();

        // Mid-send reset
        add("ms_vp_on", 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        ent("ms_d5", 1'b1, 4'h5, 16'h0005, 3'd1);
        ent("ms_d6", 1'b1, 4'h6, 16'h0056, 3'd2);
        ent("ms_d7", 1'b1, 4'h7, 16'h0567, 3'd3);
        ent("ms_d8", 1'b1, 4'h8, 16'h5678, 3'd4);
        add("ms_enter", 1'b0, 1'b1, 1'b1, 4'hB, 1'b0, 1'b0, 1'b0, 16'h5678, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        add("ms_rst_in_send", 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add("ms_idle_after", 1'b0, 1'b0, 1'b1, 4'h1, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        foreach (vecs[i]) apply(vecs[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/parking_pin_entry.md
# parking_pin_entry

Keypad-side PIN entry terminal for the parking gate. It collects four BCD digits from a keypad scanner, presents them as a 16-bit code with a one-cycle `code_ack` strobe to the gate controller, then waits for the controller's verdict. It sits between the keypad scanner and the gate controller's `code`/`code_ack` inputs, and drives user-facing status lines.

## Interface
- `ENTRY_TIMEOUT`, default 1000: idle cycles in ENTRY before a partial entry is discarded.
- `RESP_TIMEOUT`, default 16: cycles in WAIT_RESP without a verdict before the attempt is treated as rejected.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `vehicle_present`  in  1  a vehicle is at the gate; enables entry.
- `key_valid`  in  1  one-cycle strobe; `key_code` is valid while this is high.
- `key_code`  in  4  0x0–0x9 digit, 0xA clear, 0xB enter, 0xC–0xF ignored.
- `open_gate`  in  1  controller verdict: accepted.
- `wrong_ping`  in  1  controller verdict: rejected.
- `blocked_gate`  in  1  controller verdict: blocked.
- `code`  out  16  BCD; first digit in [15:12], last digit in [3:0].
- `code_ack`  out  1  one-cycle strobe; `code` is valid and stable while high.
- `digit_count`  out  3  digits entered, 0–4.
- `busy`  out  1  high in SEND and WAIT_RESP.
- `result_ok`  out  1  one-cycle pulse on acceptance.
- `result_bad`  out  1  one-cycle pulse on rejection or response timeout.
- `locked`  out  1  level; high in LOCKED.

## Operation
- States: IDLE, ENTRY, SEND, WAIT_RESP, LOCKED.
- Reset values: state IDLE, `code`=0, `digit_count`=0, timers=0, all 1-bit outputs 0.
- IDLE:
  - `code` and `digit_count` are held at 0.
  - `vehicle_present`=1 → ENTRY.
  - Keys are ignored.
- ENTRY, on a digit key:
  - If `digit_count`<4: `code` ← {code[11:0], digit}, count+1.
  - At count 4, further digits are ignored and `code` is unchanged.
- ENTRY, other events:
  - Clear (0xA): `code`=0, count=0.
  - Enter (0xB) with count==4 → SEND.
  - Enter with count<4 is ignored.
  - Keys 0xC–0xF are ignored and do not restart the timer.
  - Entry timer restarts on every accepted key (digit, clear or enter). On reaching ENTRY_TIMEOUT-1: `code`=0, count=0, timer=0, stay in ENTRY.
  - `vehicle_present`=0 → IDLE, clearing `code` and count. This takes priority over any same-cycle key.
- SEND:
  - `code_ack`=1 for exactly one cycle, then → WAIT_RESP.
  - `code` is held.
- WAIT_RESP:
  - Keys are ignored and `code` is held.
  - Verdict priority: `blocked_gate` > `open_gate` > `wrong_ping`.
  - `blocked_gate` → LOCKED.
  - `open_gate` → pulse `result_ok`, clear `code`/count, → IDLE.
  - `wrong_ping` → pulse `result_bad`, clear `code`/count, → ENTRY with entry timer reset.
  - Response timer reaching RESP_TIMEOUT-1 with no verdict → same as `wrong_ping`.
  - `vehicle_present` is ignored in this state.
- LOCKED:
  - `locked`=1 and all inputs are ignored; `code` is held.
  - Exit only via `rst`.
- Counter widths: timers are sized by $clog2 of their parameter; `digit_count` saturates at 4.

## Timing
- A key strobed in cycle t updates `code`/`digit_count` at t+1 (registered).
- Enter at t: SEND at t+1 with `code_ack` high during t+1 only; WAIT_RESP from t+2.
- Verdict inputs are first sampled at t+2.
- A verdict sampled at cycle v: the `result_*` pulse, the state change and the `code` clear are all visible at v+1.
- Response timer counts from 0 at WAIT_RESP entry. Timeout fires after RESP_TIMEOUT cycles in WAIT_RESP.
- `rst` mid-operation, including during SEND, drops `code_ack` on the next edge and returns all outputs to reset values.
- All outputs are registered; there are no combinational input→output paths.

## Structure
- Shared package holds:
  - state encodings (PE_IDLE, PE_ENTRY, PE_SEND, PE_WAIT_RESP, PE_LOCKED);
  - key constants KEY_CLEAR=4'hA, KEY_ENTER=4'hB;
  - PIN_DIGITS=4.
- One sub-module: `pe_timeout_counter`, parameterized by limit, with `clear`/`enable`/`expired`, and expiry as a registered pulse. Instantiated twice, once for the entry timer and once for the response timer.

## Test plan
- **Accepted PIN:** reset, `vehicle_present`=1, keys 2,4,6,8, enter; `open_gate`=1 two cycles later → `code_ack` one cycle with `code`=16'h2468, `result_ok` pulse, state IDLE, `code`=0.
- **Editing:** digits 1,2,3,4,5, clear, 9,9, enter → 5th digit ignored (`code`=16'h1234), after clear `code`=0, final `code`=16'h0099 with count 2, enter ignored, no `code_ack`.
- **Rejection:** send 16'h1111, assert `wrong_ping` → `result_bad` pulse, state ENTRY, `code`=0. Repeat without any verdict → `result_bad` exactly RESP_TIMEOUT cycles after WAIT_RESP entry.
- **Lockout:** `blocked_gate` and `open_gate` asserted in the same cycle in WAIT_RESP → `locked`=1, no `result_ok`, keys ignored thereafter, `rst` clears `locked`.
- **Entry timeout and departure:** with ENTRY_TIMEOUT=8, enter 3,3 then idle 8 cycles → `code`=0, count 0. Enter a digit, then drop `vehicle_present` in the same cycle as a digit key → IDLE, `code`=0.
- **Mid-send reset:** enter, then `rst` high in the SEND cycle → the next cycle shows `code_ack`=0, all outputs at reset values, state IDLE.
